// File: rtl/pwm_generator_if.sv
// -----------------------------------------------------------------------------
// pwm_generator_if
//
// Update handshake between the angle controller (master) and the PWM
// generator (slave). The controller presents a duty ratio and a direction
// together with pwm_update; the generator answers with pwm_done once the new
// values are active on the driver outputs.
//
// Signals
//   pwm_update     master -> slave  request to apply pwm_ratio/pwm_direction
//   pwm_ratio[7:0] master -> slave  requested high time out of 255 counts
//   pwm_direction  master -> slave  requested motor direction
//   pwm_done       slave -> master  acknowledge, new ratio is active
// -----------------------------------------------------------------------------
interface pwm_generator_if;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;

    modport master (
        output pwm_update,
        output pwm_ratio,
        output pwm_direction,
        input  pwm_done
    );

    modport slave (
        input  pwm_update,
        input  pwm_ratio,
        input  pwm_direction,
        output pwm_done
    );
endinterface

// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//
// Motor PWM generator. A prescaler divides the clock into count ticks and an
// 8-bit period counter runs 0..254, giving a period of 255 * PRESCALE clocks.
// The output is high while the period counter is below the active duty ratio.
//
// New ratio/direction requests arrive on a 4-phase handshake. A request is
// captured into pending registers when accepted and is only made active at a
// period boundary, so a running period is never cut short. The direction
// output is retimed to the same boundary. When the generator is disabled
// there is no period to protect and the request is applied on the next edge.
//
// Ports
//   clock        main clock, all logic on the rising edge
//   reset_n      synchronous, active-low reset
//   pwm_enable   1 = run, 0 = output low and counters held at 0
//   bus          handshake (slave side): pwm_update, pwm_ratio,
//                pwm_direction in; pwm_done out
//   pwm_signal   registered PWM waveform to the motor driver
//   pwm_dir_out  registered direction to the motor driver
//
// Parameter
//   PRESCALE     clocks per count tick (>= 1)
// -----------------------------------------------------------------------------
module pwm_generator #(
    parameter int PRESCALE = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           pwm_enable,
    pwm_generator_if.slave bus,
    output logic           pwm_signal,
    output logic           pwm_dir_out
);

    // A one-bit prescaler is kept for PRESCALE == 1 so the vector is never
    // zero width; it simply stays at 0 and every cycle is a tick.
    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]      COUNT_LAST = 8'd254;
    localparam logic [7:0]      NEUTRAL    = 8'd128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   presc_reg;
    logic [7:0]      count_reg;
    logic [7:0]      active_ratio_reg;
    logic [7:0]      pending_ratio_reg;
    logic            pending_dir_reg;
    logic            done_reg;

    logic            tick;
    logic            boundary;

    // A tick only exists while enabled; with the enable low both counters
    // are frozen at zero and no boundary can occur.
    assign tick     = pwm_enable && (presc_reg == PRESC_LAST);
    assign boundary = tick && (count_reg == COUNT_LAST);

    assign bus.pwm_done = done_reg;

    // -------------------------------------------------------------------------
    // Prescaler and period counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            presc_reg <= '0;
            count_reg <= '0;
        end else if (!pwm_enable) begin
            presc_reg <= '0;
            count_reg <= '0;
        end else begin
            if (tick) begin
                presc_reg <= '0;
                // Wrapping 254 -> 0 is what starts the new period, which
                // is also the edge at which a pending ratio becomes active.
                if (count_reg == COUNT_LAST) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_reg + 8'd1;
                end
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Waveform: compare uses the pre-edge count and ratio, so the output lags
    // the counter by one register stage. count never exceeds 254, so ratio
    // 255 is a constant high and ratio 0 a constant low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pwm_signal <= 1'b0;
        end else begin
            pwm_signal <= pwm_enable && (count_reg < active_ratio_reg);
        end
    end

    // -------------------------------------------------------------------------
    // Update handshake FSM with registered pwm_done / pwm_dir_out
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            active_ratio_reg  <= NEUTRAL;
            pending_ratio_reg <= NEUTRAL;
            pending_dir_reg   <= 1'b0;
            pwm_dir_out       <= 1'b0;
            done_reg          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Values are captured at acceptance; later changes on
                    // the bus while waiting for the boundary are ignored.
                    if (bus.pwm_update) begin
                        pending_ratio_reg <= bus.pwm_ratio;
                        pending_dir_reg   <= bus.pwm_direction;
                        state_reg         <= PENDING;
                    end
                end

                PENDING: begin
                    // Disabled means no period is running, so there is
                    // nothing to truncate and no boundary will ever come.
                    if (boundary || !pwm_enable) begin
                        active_ratio_reg <= pending_ratio_reg;
                        pwm_dir_out      <= pending_dir_reg;
                        done_reg         <= 1'b1;
                        state_reg        <= DONE;
                    end
                end

                DONE: begin
                    // Holding pwm_update high here must not start a second
                    // transfer; only a fresh rise seen from IDLE does.
                    if (!bus.pwm_update) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
module tb_pwm_generator;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic en_a, en_b;
    logic sig_a, dir_a, sig_b, dir_b;

    pwm_generator_if bus_a();
    pwm_generator_if bus_b();

    // dut_a: PRESCALE=1 (255-clock period), dut_b: PRESCALE=4 (1020-clock period)
    pwm_generator #(.PRESCALE(1)) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .pwm_enable  (en_a),
        .bus         (bus_a),
        .pwm_signal  (sig_a),
        .pwm_dir_out (dir_a)
    );

    pwm_generator #(.PRESCALE(4)) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .pwm_enable  (en_b),
        .bus         (bus_b),
        .pwm_signal  (sig_b),
        .pwm_dir_out (dir_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive(input bit b, input logic upd, input logic [7:0] r, input logic d);
        if (b) begin
            bus_b.pwm_update    = upd;
            bus_b.pwm_ratio     = r;
            bus_b.pwm_direction = d;
        end else begin
            bus_a.pwm_update    = upd;
            bus_a.pwm_ratio     = r;
            bus_a.pwm_direction = d;
        end
    endtask

    task automatic set_update(input bit b, input logic upd);
        if (b) bus_b.pwm_update = upd;
        else   bus_a.pwm_update = upd;
    endtask

    function automatic logic done_of(input bit b);
        return b ? bus_b.pwm_done : bus_a.pwm_done;
    endfunction

    function automatic logic sig_of(input bit b);
        return b ? sig_b : sig_a;
    endfunction

    task automatic count_high(input bit b, input int n, output int h);
        h = 0;
        repeat (n) begin
            step(1);
            if (sig_of(b) === 1'b1) h++;
        end
    endtask

    // Bounded wait for pwm_done; lat = samples after the request was raised.
    task automatic wait_done(input bit b, output int lat);
        lat = 0;
        while (lat < 1100) begin
            step(1);
            lat++;
            if (done_of(b) === 1'b1) break;
        end
        total++;
        if (done_of(b) !== 1'b1)
            $display("FAIL done_wait: pwm_done=%0b after %0d cycles, expected 1", done_of(b), lat);
        else passed++;
        $display("txn: dut%s done after %0d cycles", b ? "_b" : "_a", lat);
    endtask

    task automatic test_reset();
        int h;
        reset_n = 1'b0;
        en_a = 1'b1;
        en_b = 1'b0;
        drive(0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 8'd0, 1'b0);
        step(3);
        total++; if (sig_a !== 1'b0) $display("FAIL reset_sig_a: got %0b, expected 0", sig_a); else passed++;
        total++; if (bus_a.pwm_done !== 1'b0) $display("FAIL reset_done_a: got %0b, expected 0", bus_a.pwm_done); else passed++;
        total++; if (dir_a !== 1'b0) $display("FAIL reset_dir_a: got %0b, expected 0", dir_a); else passed++;
        total++; if (sig_b !== 1'b0) $display("FAIL reset_sig_b: got %0b, expected 0", sig_b); else passed++;
        reset_n = 1'b1;
        count_high(0, 255, h);
        total++; if (h !== 128) $display("FAIL reset_ratio_p1: high=%0d, expected 128", h); else passed++;
        count_high(0, 255, h);
        total++; if (h !== 128) $display("FAIL reset_ratio_p2: high=%0d, expected 128", h); else passed++;
        total++; if (bus_a.pwm_done !== 1'b0) $display("FAIL reset_done_run: got %0b, expected 0", bus_a.pwm_done); else passed++;
        $display("txn: reset defaults, 255-cycle windows high=%0d", h);
    endtask

    task automatic test_boundary();
        int lat, h;
        en_b = 1'b1;
        step(300);
        drive(1, 1'b1, 8'd64, 1'b1);
        wait_done(1, lat);
        // accepted at edge 301, boundary at edge 1020 -> 720 samples
        total++; if (lat !== 720) $display("FAIL boundary_latency: got %0d, expected 720", lat); else passed++;
        total++; if (dir_b !== 1'b1) $display("FAIL boundary_dir: got %0b, expected 1", dir_b); else passed++;
        set_update(1, 1'b0);
        step(1);
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL boundary_done_drop: got %0b, expected 0", bus_b.pwm_done); else passed++;
        total++; if (sig_b !== 1'b1) $display("FAIL boundary_first_sample: got %0b, expected 1", sig_b); else passed++;
        count_high(1, 1020, h);
        total++; if (h !== 256) $display("FAIL boundary_high_p1: high=%0d, expected 256", h); else passed++;
        count_high(1, 1020, h);
        total++; if (h !== 256) $display("FAIL boundary_high_p2: high=%0d, expected 256", h); else passed++;
        $display("txn: boundary update ratio 64, latency %0d, high=%0d", lat, h);
    endtask

    task automatic test_handshake();
        int lat, h, held, late;
        drive(1, 1'b1, 8'd100, 1'b1);
        wait_done(1, lat);
        held = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'b1, 8'd7, 1'b0);
            step(1);
            if (bus_b.pwm_done === 1'b1) held++;
        end
        total++; if (held !== 10) $display("FAIL hs_done_held: high=%0d, expected 10", held); else passed++;
        set_update(1, 1'b0);
        step(1);
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL hs_done_drop: got %0b, expected 0", bus_b.pwm_done); else passed++;
        late = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus_b.pwm_done !== 1'b0) late++;
        end
        total++; if (late !== 0) $display("FAIL hs_no_reaccept: done high %0d cycles, expected 0", late); else passed++;
        total++; if (dir_b !== 1'b1) $display("FAIL hs_dir: got %0b, expected 1", dir_b); else passed++;
        count_high(1, 1020, h);
        total++; if (h !== 400) $display("FAIL hs_ratio: high=%0d, expected 400", h); else passed++;
        $display("txn: handshake ratio 100 held 10, high=%0d", h);
    endtask

    task automatic test_extremes();
        int lat, h;
        drive(0, 1'b1, 8'd0, 1'b0);
        wait_done(0, lat);
        set_update(0, 1'b0);
        step(1);
        total++; if (bus_a.pwm_done !== 1'b0) $display("FAIL ext0_done_drop: got %0b, expected 0", bus_a.pwm_done); else passed++;
        count_high(0, 510, h);
        total++; if (h !== 0) $display("FAIL ext_ratio0: high=%0d, expected 0", h); else passed++;
        $display("txn: ratio 0, high=%0d of 510", h);
        drive(0, 1'b1, 8'd255, 1'b1);
        wait_done(0, lat);
        set_update(0, 1'b0);
        step(1);
        count_high(0, 510, h);
        total++; if (h !== 510) $display("FAIL ext_ratio255: high=%0d, expected 510", h); else passed++;
        total++; if (dir_a !== 1'b1) $display("FAIL ext_dir: got %0b, expected 1", dir_a); else passed++;
        $display("txn: ratio 255, high=%0d of 510", h);
    endtask

    task automatic test_disabled();
        int h;
        en_b = 1'b0;
        step(2);
        total++; if (sig_b !== 1'b0) $display("FAIL dis_sig_low: got %0b, expected 0", sig_b); else passed++;
        drive(1, 1'b1, 8'd200, 1'b0);
        step(1);
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL dis_accept_edge: got %0b, expected 0", bus_b.pwm_done); else passed++;
        step(1);
        total++; if (bus_b.pwm_done !== 1'b1) $display("FAIL dis_done_1cycle: got %0b, expected 1", bus_b.pwm_done); else passed++;
        total++; if (dir_b !== 1'b0) $display("FAIL dis_dir: got %0b, expected 0", dir_b); else passed++;
        total++; if (sig_b !== 1'b0) $display("FAIL dis_sig_after_apply: got %0b, expected 0", sig_b); else passed++;
        set_update(1, 1'b0);
        step(1);
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL dis_done_drop: got %0b, expected 0", bus_b.pwm_done); else passed++;
        en_b = 1'b1;
        count_high(1, 1020, h);
        total++; if (h !== 800) $display("FAIL dis_first_period: high=%0d, expected 800", h); else passed++;
        $display("txn: disabled apply ratio 200, first period high=%0d", h);
    endtask

    task automatic test_late_change_reset();
        int lat, h;
        drive(1, 1'b1, 8'd30, 1'b1);
        step(1);
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL late_accept: got %0b, expected 0", bus_b.pwm_done); else passed++;
        drive(1, 1'b1, 8'd220, 1'b0);
        wait_done(1, lat);
        total++; if (dir_b !== 1'b1) $display("FAIL late_dir: got %0b, expected 1", dir_b); else passed++;
        set_update(1, 1'b0);
        step(1);
        count_high(1, 1020, h);
        total++; if (h !== 120) $display("FAIL late_ratio: high=%0d, expected 120", h); else passed++;
        $display("txn: late change, captured ratio 30 high=%0d", h);

        drive(1, 1'b1, 8'd90, 1'b0);
        step(1);
        reset_n = 1'b0;
        set_update(1, 1'b0);
        step(1);
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL rst_pend_done: got %0b, expected 0", bus_b.pwm_done); else passed++;
        total++; if (dir_b !== 1'b0) $display("FAIL rst_pend_dir: got %0b, expected 0", dir_b); else passed++;
        total++; if (sig_b !== 1'b0) $display("FAIL rst_pend_sig: got %0b, expected 0", sig_b); else passed++;
        reset_n = 1'b1;
        count_high(1, 1020, h);
        total++; if (h !== 512) $display("FAIL rst_pend_ratio: high=%0d, expected 512", h); else passed++;
        total++; if (bus_b.pwm_done !== 1'b0) $display("FAIL rst_pend_discard: got %0b, expected 0", bus_b.pwm_done); else passed++;
        $display("txn: reset in pending, ratio 128 high=%0d", h);
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_handshake();
        test_extremes();
        test_disabled();
        test_late_change_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Produces the motor PWM waveform from the 8-bit duty ratio requested by the angle controller, and is the responder side of the `pwm_update`/`pwm_done` handshake. A new ratio is accepted, held pending, and applied only at a PWM period boundary so no period is ever truncated. It then acknowledges with `pwm_done`. The block sits between the angle-to-PWM control logic and the motor driver pin, and also retimes the direction bit to the same boundary.

## Interface
- `PRESCALE`, default 4: clocks per PWM count tick (≥1); period = 255 × `PRESCALE` clocks.
- `clock`  in  1  main clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `pwm_enable`  in  1  1 = generate waveform; 0 = output forced low, counters held at 0.
- `pwm_update`  in  1  request to apply `pwm_ratio`/`pwm_direction`; 4-phase handshake with `pwm_done`.
- `pwm_ratio`  in  8  requested high-time out of 255.
- `pwm_direction`  in  1  requested motor direction.
- `pwm_done`  out  1  acknowledge: new ratio is active.
- `pwm_signal`  out  1  PWM waveform to the driver, registered.
- `pwm_dir_out`  out  1  direction to the driver, registered, changes only with ratio.

## Operation

**Reset values**
- `pwm_done`=0, `pwm_signal`=0, `pwm_dir_out`=0.
- Active ratio=128 (neutral), pending ratio=128.
- Tick counter `presc`=0, period counter `count`=0, state IDLE.

**Counters**
- `presc` runs 0..`PRESCALE`-1. A tick occurs in a cycle where `presc`==`PRESCALE`-1.
- On a tick, `count` increments 0..254 and wraps 254→0.
- A boundary is a tick with `count`==254.
- With `pwm_enable`=0, both counters are held at 0. There is no tick.

**Waveform**
- `pwm_signal` is registered as `pwm_enable` AND (`count` < active ratio), using pre-edge values.
- Ratio 0 gives a constant low. Ratio 255 gives a constant high.
- Compare is unsigned, 8-bit.

**Handshake FSM (IDLE, PENDING, DONE)**
- IDLE: if `pwm_update`=1 is sampled, capture `pwm_ratio` and `pwm_direction` into the pending registers, then go to PENDING. `pwm_done` stays 0.
- PENDING: wait for a boundary. Input changes are ignored; the values were captured at acceptance.
  - At the boundary edge: `count`←0, active ratio←pending, `pwm_dir_out`←pending direction, `pwm_done`←1, go to DONE.
  - If `pwm_enable`=0: apply on the next edge unconditionally, with no boundary wait.
- DONE: `pwm_done` is held at 1 while `pwm_update`=1. When `pwm_update`=0 is sampled: `pwm_done`←0, go to IDLE.
- A new request is accepted only from IDLE. If `pwm_update` is held through DONE, it is not re-accepted until it drops and rises again.

**Enable edges**
- `pwm_enable` falling: takes effect at the next edge. `pwm_signal`=0 and counters=0; the active ratio is retained.
- `pwm_enable` rising: a fresh period starts at `count`=0.

## Timing
- Acceptance: `pwm_update` sampled high in IDLE at edge N → PENDING after edge N.
- Apply latency from acceptance to `pwm_done`=1:
  - at least 1 cycle, at most 255 × `PRESCALE` cycles, when enabled;
  - exactly 1 cycle when disabled.
- `pwm_done` deasserts 1 cycle after `pwm_update` is sampled low.
- Minimum full handshake when disabled: update high → done high (1 cycle), update low → done low (1 cycle).
- The new ratio affects `pwm_signal` from the first cycle of the new period. `pwm_signal` lags `count` by 1 register stage.
- High time per period = ratio × `PRESCALE` clocks.
- Reset asserted mid-handshake or mid-period: all state returns to the reset values at that edge, and the pending request is discarded.

## Test plan
- **Reset defaults:** deassert reset with `PRESCALE`=1, `pwm_enable`=1 → ratio 128 active; `pwm_signal` high 128 of every 255 cycles; `pwm_done`=0.
- **Boundary-aligned update:** `PRESCALE`=4, request ratio 64 mid-period → `pwm_done` rises at the first boundary; every later period is high for exactly 256 clocks out of 1020.
- **Four-phase handshake:** hold `pwm_update` high for 10 cycles after `pwm_done` → `pwm_done` stays 1 and there is no second accept; drop `pwm_update` → `pwm_done`=0 one cycle later.
- **Extremes:** ratio 0 → `pwm_signal` constantly 0; ratio 255 → constantly 1 across full periods.
- **Disabled path:** `pwm_enable`=0, request ratio 200 → `pwm_done` 1 cycle after acceptance, `pwm_signal`=0; enable → first period high for 200 ticks.
- **Late-change and reset:** change `pwm_ratio` while in PENDING → the originally captured value is applied. Assert `reset_n`=0 in PENDING → `pwm_done`=0 and ratio 128 on the next edge.
